burst_arbiter: RTL and testbench

- Round-robin arbiter/scheduler sharing one valid/ready stream port (e.g. a shared memory or accelerator write port) between N_REQ requesters.
- Holds a grant for a whole burst whose length is latched at grant time, muxes the winner's stream onto the shared port and flags the last beat.
- A stall watchdog aborts a burst that stops making progress.
- Sits between the accelerator's DMA/engine clients and the single shared slave port.

---
 rtl/burst_arb_pkg.sv | 35 +++
 rtl/rr_picker.sv | 35 +++
 rtl/burst_arbiter.sv | 127 ++++++++++++
 tb/tb_burst_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/burst_arb_pkg.sv
// Shared types and helpers for the burst arbiter and its round-robin picker.
package burst_arb_pkg;

  // Arbiter FSM encoding, kept as plain constants for legacy tooling.
  typedef logic [0:0] state_t;
  localparam state_t StIdle = 1'b0;
  localparam state_t StXfer = 1'b1;

  // Widest request vector rr_pick handles; callers zero-extend into it.
  localparam int unsigned MaxReq = 32;

  // Round-robin select: lowest set bit at or above ptr, else lowest set bit
  // overall. Returns a one-hot vector, or zero when no request is set.
  function automatic logic [MaxReq-1:0] rr_pick(input logic [MaxReq-1:0] req,
                                                input int unsigned      ptr);
    logic [MaxReq-1:0] masked;
    logic [MaxReq-1:0] src;
    logic [MaxReq-1:0] pick;
    logic              found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      masked[i] = req[i] & (i >= ptr);
    end
    src = (|masked) ? masked : req;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      if (src[i] && !found) begin
        pick[i] = 1'b1;
        found   = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: masked/unmasked priority select plus
// one-hot to index encode. N must be below burst_arb_pkg::MaxReq.
module rr_picker
  import burst_arb_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    pick_oh_o,
  output logic [IdxW-1:0] pick_idx_o,
  output logic            any_o
);

  logic [MaxReq-1:0] req_ext;
  logic [MaxReq-1:0] pick_ext;
  logic              unused_pick_hi;

  assign req_ext        = MaxReq'(req_i);
  assign pick_ext       = rr_pick(req_ext, 32'(ptr_i));
  assign pick_oh_o      = pick_ext[N-1:0];
  // Bits above N are always zero since the request was zero-extended.
  assign unused_pick_hi = ^pick_ext[MaxReq-1:N];
  assign any_o          = |req_i;

  // Encode the one-hot winner into a requester index.
  always_comb begin
    pick_idx_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pick_oh_o[i]) pick_idx_o = IdxW'(i);
    end
  end

endmodule

// File: rtl/burst_arbiter.sv
// Round-robin burst arbiter: grants one requester a whole burst on the shared
// valid/ready port, marks the last beat, and aborts bursts that stall.
module burst_arbiter
  import burst_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*LEN_W-1:0]     len,
  input  logic [N_REQ-1:0]           m_valid,
  input  logic [N_REQ*DATA_W-1:0]    m_data,
  output logic [N_REQ-1:0]           m_ready,
  output logic                       s_valid,
  output logic [DATA_W-1:0]          s_data,
  output logic                       s_last,
  input  logic                       s_ready,
  output logic                       gnt,
  output logic [$clog2(N_REQ)-1:0]   gnt_id,
  output logic                       abort
);

  localparam int unsigned IdxW   = $clog2(N_REQ);
  localparam int unsigned StallW = $clog2(TIMEOUT);
  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(N_REQ - 1);
  localparam logic [StallW-1:0] StallMax = StallW'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [IdxW-1:0]     gnt_id_q, gnt_id_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    beat_q, beat_d;
  logic [StallW-1:0]   stall_q, stall_d;

  logic [N_REQ-1:0]    unused_win_oh;
  logic [IdxW-1:0]     win_idx;
  logic                any_req;
  logic                beat;
  logic                burst_end;
  logic                grant_now;

  rr_picker #(
    .N    (N_REQ),
    .IdxW (IdxW)
  ) u_picker (
    .req_i      (req),
    .ptr_i      (ptr_q),
    .pick_oh_o  (unused_win_oh),
    .pick_idx_o (win_idx),
    .any_o      (any_req)
  );

  assign gnt    = (state_q == StXfer);
  assign gnt_id = gnt_id_q;

  // Route the granted requester onto the shared port; everything gated by gnt.
  always_comb begin
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = '0;
    if (gnt) begin
      s_valid          = m_valid[gnt_id_q];
      s_data           = m_data[gnt_id_q*DATA_W +: DATA_W];
      m_ready[gnt_id_q] = s_ready;
    end
  end

  assign s_last    = gnt & (beat_q == len_q);
  assign beat      = s_valid & s_ready;
  assign abort     = gnt & ~beat & (stall_q == StallMax);
  assign burst_end = (beat & s_last) | abort;
  // Arbitrate when idle, or back-to-back at the end of a burst (no bubble).
  assign grant_now = any_req & (~gnt | burst_end);

  // Next-state: grant issue, burst completion, beat and stall counting.
  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    beat_d   = beat_q;
    stall_d  = stall_q;
    if (grant_now) begin
      state_d  = StXfer;
      gnt_id_d = win_idx;
      len_d    = len[win_idx*LEN_W +: LEN_W];
      beat_d   = '0;
      stall_d  = '0;
      ptr_d    = (win_idx == LastIdx) ? '0 : win_idx + 1'b1;
    end else if (burst_end) begin
      state_d = StIdle;
      beat_d  = '0;
      stall_d = '0;
    end else if (gnt) begin
      if (beat) begin
        beat_d  = beat_q + 1'b1;
        stall_d = '0;
      end else begin
        stall_d = stall_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset that overrides any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      gnt_id_q <= '0;
      ptr_q    <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      ptr_q    <= ptr_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      stall_q  <= stall_d;
    end
  end

endmodule

// File: tb/tb_burst_arbiter.sv
// Directed bench for burst_arbiter with hand-computed expectations.
module tb_burst_arbiter;

  localparam int unsigned NReq  = 4;
  localparam int unsigned DataW = 32;
  localparam int unsigned LenW  = 8;

  logic                   clk;
  logic                   rst;
  logic [NReq-1:0]        req;
  logic [NReq*LenW-1:0]   len;
  logic [NReq-1:0]        m_valid;
  logic [NReq*DataW-1:0]  m_data;
  logic [NReq-1:0]        m_ready;
  logic                   s_valid;
  logic [DataW-1:0]       s_data;
  logic                   s_last;
  logic                   s_ready;
  logic                   gnt;
  logic [1:0]             gnt_id;
  logic                   abort;

  int ntot;
  int nbad;
  int beats;

  burst_arbiter #(
    .N_REQ   (NReq),
    .DATA_W  (DataW),
    .LEN_W   (LenW),
    .TIMEOUT (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .len     (len),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_ready (s_ready),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .abort   (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    req     = '0;
    len     = '0;
    m_valid = 4'hf;
    s_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    ntot   = 0;
    nbad   = 0;
    m_data = 128'h000000d3_000000d2_000000d1_000000d0;
    do_reset();

    // Reset state
    #1;
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_gnt_id", 64'(gnt_id), 64'd0);
    check("rst_abort", 64'(abort), 64'd0);
    check("rst_s_valid", 64'(s_valid), 64'd0);
    check("rst_m_ready", 64'(m_ready), 64'd0);

    // Single requester, 4 beats
    req = 4'b0001;
    len[0*LenW +: LenW] = 8'd3;
    #1;
    check("t1_no_gnt_yet", 64'(gnt), 64'd0);
    tick();
    for (int b = 0; b < 4; b++) begin
      #1;
      check("t1_gnt", 64'(gnt), 64'd1);
      check("t1_gnt_id", 64'(gnt_id), 64'd0);
      check("t1_s_last", 64'(s_last), 64'(b == 3));
      check("t1_s_data", 64'(s_data), 64'hd0);
      check("t1_m_ready", 64'(m_ready), 64'b0001);
      req = '0;
      tick();
    end
    #1;
    check("t1_gnt_after", 64'(gnt), 64'd0);
    check("t1_id_hold", 64'(gnt_id), 64'd0);

    // Fairness, back-to-back single-beat bursts
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 8; k++) begin
      #1;
      check("t2_gnt", 64'(gnt), 64'd1);
      check("t2_gnt_id", 64'(gnt_id), 64'(k % 4));
      check("t2_s_last", 64'(s_last), 64'd1);
      check("t2_s_data", 64'(s_data), 64'(8'hd0 + 8'(k % 4)));
      tick();
    end

    // Backpressure on a 2-beat burst
    do_reset();
    req = 4'b0100;
    len[2*LenW +: LenW] = 8'd1;
    tick();
    beats = 0;
    for (int c = 0; c < 3; c++) begin
      s_ready = (c != 1);
      #1;
      check("t3_gnt_id", 64'(gnt_id), 64'd2);
      check("t3_m_ready", 64'(m_ready), (c != 1) ? 64'b0100 : 64'b0000);
      check("t3_s_last", 64'(s_last), 64'(c >= 1));
      if (s_valid && s_ready) beats++;
      req = '0;
      tick();
    end
    #1;
    check("t3_gnt_after", 64'(gnt), 64'd0);
    check("t3_beats", 64'(beats), 64'd2);

    // Request dropped mid-burst
    do_reset();
    req = 4'b0010;
    len[1*LenW +: LenW] = 8'd5;
    tick();
    for (int b = 0; b < 6; b++) begin
      #1;
      check("t4_gnt", 64'(gnt), 64'd1);
      check("t4_gnt_id", 64'(gnt_id), 64'd1);
      check("t4_s_last", 64'(s_last), 64'(b == 5));
      if (b == 1) req = '0;
      tick();
    end
    #1;
    check("t4_gnt_after", 64'(gnt), 64'd0);

    // Watchdog abort, then hand-off to pending requester 3
    do_reset();
    req = 4'b0001;
    len[0*LenW +: LenW] = 8'd3;
    len[3*LenW +: LenW] = 8'd0;
    tick();
    #1;
    check("t5_first_beat", 64'(s_valid && s_ready), 64'd1);
    req = 4'b1000;
    tick();
    for (int c = 1; c <= 8; c++) begin
      m_valid = 4'b1110;
      #1;
      check("t5_abort", 64'(abort), 64'(c == 8));
      check("t5_gnt_id", 64'(gnt_id), 64'd0);
      tick();
    end
    #1;
    check("t5_abort_clear", 64'(abort), 64'd0);
    check("t5_gnt", 64'(gnt), 64'd1);
    check("t5_gnt_id_next", 64'(gnt_id), 64'd3);
    check("t5_s_last", 64'(s_last), 64'd1);
    req = '0;
    tick();
    #1;
    check("t5_gnt_after", 64'(gnt), 64'd0);

    // Reset mid-burst, then restart with pointer back at 0
    do_reset();
    req = 4'b0001;
    len[0*LenW +: LenW] = 8'd3;
    tick();
    #1;
    check("t6_beat1_last", 64'(s_last), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    #1;
    check("t6_gnt", 64'(gnt), 64'd0);
    check("t6_s_valid", 64'(s_valid), 64'd0);
    check("t6_m_ready", 64'(m_ready), 64'd0);
    rst = 1'b0;
    req = 4'b1001;
    tick();
    for (int b = 0; b < 4; b++) begin
      #1;
      check("t6_gnt_id", 64'(gnt_id), 64'd0);
      check("t6_s_last", 64'(s_last), 64'(b == 3));
      tick();
    end
    #1;
    check("t6_next_id", 64'(gnt_id), 64'd3);
    req = '0;

    // Maximum length: 256 beats without wrapping
    do_reset();
    req = 4'b0001;
    len[0*LenW +: LenW] = 8'hff;
    tick();
    for (int b = 0; b < 256; b++) begin
      #1;
      if (b == 0 || b >= 254) check("t7_s_last", 64'(s_last), 64'(b == 255));
      req = '0;
      tick();
    end
    #1;
    check("t7_gnt_after", 64'(gnt), 64'd0);

    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

endmodule
